rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/rst_sync_chain.sv | 22 ++
 rtl/rst_seq.sv | 123 ++++++++++++
 tb/tb_rst_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and sizing helpers for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_state_t;

    // One counter serves both the hold and stagger phases, so size it for the larger.
    function automatic int cnt_width(input int hold_cycles, input int stagger);
        int m;
        m = (hold_cycles > stagger) ? hold_cycles : stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rtl/rst_sync_chain.sv - async-assert / sync-deassert reset synchroniser chain
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic areset_n,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], 1'b1};
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset sequencer: sync, hold, then staggered per-channel release
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_CH      = 3,
    parameter int STAGGER     = 2
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              sw_req,
    output logic [NUM_CH-1:0] reset_out,
    output logic              ready
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER);
    localparam int CH_W  = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    logic              sync_q;
    rst_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              rdy_q, rdy_d;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .areset_n (areset_n),
        .q        (sync_q)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        rdy_d   = rdy_q;

        // Software reset restarts the hold phase; the sync chain is left alone.
        if (sw_req && (state_q != ASSERT)) begin
            state_d = HOLD;
            cnt_d   = '0;
            ch_d    = '0;
            rst_d   = '1;
            rdy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    if (sync_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        if (NUM_CH == 1) begin
                            state_d = RUN;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            ch_d    = CH_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (CH_W'(i) == ch_q) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        ch_d = ch_q + CH_W'(1);
                        if (ch_q == CH_LAST) begin
                            state_d = RUN;
                            rdy_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_d = '0;
                    rdy_d = 1'b1;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    assign reset_out = rst_q;
    assign ready     = rdy_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed self-checking bench for rst_seq
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       a_n;
    logic       sw;
    logic [2:0] ro;
    logic       rdy;
    logic       a2_n;
    logic       sw2;
    logic [0:0] ro2;
    logic       rdy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rst_seq dut (
        .clk       (clk),
        .areset_n  (a_n),
        .sw_req    (sw),
        .reset_out (ro),
        .ready     (rdy)
    );

    rst_seq #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .NUM_CH      (1),
        .STAGGER     (1)
    ) dut_min (
        .clk       (clk),
        .areset_n  (a2_n),
        .sw_req    (sw2),
        .reset_out (ro2),
        .ready     (rdy2)
    );

    // {ready, reset_out} for default config, n = edges since channel 0 released
    function automatic logic [3:0] exp_of(input int n);
        if (n < 0)      return 4'b0111;
        else if (n < 2) return 4'b0110;
        else if (n < 4) return 4'b0100;
        else            return 4'b1000;
    endfunction

    task automatic test_reset();
        #1 a_n = 1'b0;
        a2_n = 1'b0;
        #1;
        total++;
        if ({rdy, ro} !== 4'b0111) begin
            bad++;
            $display("FAIL reset_immediate got %b want %b", {rdy, ro}, 4'b0111);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if ({rdy, ro} !== 4'b0111) begin
                bad++;
                $display("FAIL reset_low cyc=%0d got %b want %b", k, {rdy, ro}, 4'b0111);
            end
        end
        @(negedge clk);
        a_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            total++;
            if ({rdy, ro} !== exp_of(k - 7)) begin
                bad++;
                $display("FAIL reset_release E%0d got %b want %b", k, {rdy, ro}, exp_of(k - 7));
            end
        end
    endtask

    task automatic test_glitch();
        #2 a_n = 1'b0;
        #1;
        total++;
        if ({rdy, ro} !== 4'b0111) begin
            bad++;
            $display("FAIL glitch_immediate got %b want %b", {rdy, ro}, 4'b0111);
        end
        a_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            total++;
            if ({rdy, ro} !== exp_of(k - 7)) begin
                bad++;
                $display("FAIL glitch_release E%0d got %b want %b", k, {rdy, ro}, exp_of(k - 7));
            end
        end
    endtask

    task automatic test_sw_run();
        @(negedge clk);
        sw = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #1;
            sw = 1'b0;
            total++;
            if ({rdy, ro} !== exp_of(k - 4)) begin
                bad++;
                $display("FAIL sw_run R+%0d got %b want %b", k, {rdy, ro}, exp_of(k - 4));
            end
        end
    endtask

    task automatic test_sw_mid_release();
        @(negedge clk);
        a_n = 1'b0;
        @(negedge clk);
        a_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (k == 8) sw = 1'b1;
            @(posedge clk); #1;
            sw = 1'b0;
            total++;
            if (k < 8) begin
                if ({rdy, ro} !== exp_of(k - 7)) begin
                    bad++;
                    $display("FAIL sw_mid_pre E%0d got %b want %b", k, {rdy, ro}, exp_of(k - 7));
                end
            end else begin
                if ({rdy, ro} !== exp_of(k - 12)) begin
                    bad++;
                    $display("FAIL sw_mid_post E%0d got %b want %b", k, {rdy, ro}, exp_of(k - 12));
                end
            end
        end
    endtask

    task automatic test_sw_held_assert();
        @(negedge clk);
        a_n = 1'b0;
        sw  = 1'b1;
        @(negedge clk);
        a_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (k == 4) sw = 1'b0;
            total++;
            if ({rdy, ro} !== exp_of(k - 8)) begin
                bad++;
                $display("FAIL sw_held E%0d got %b want %b", k, {rdy, ro}, exp_of(k - 8));
            end
        end
    endtask

    task automatic test_min_config();
        logic [1:0] want;
        @(negedge clk);
        a2_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            want = (k < 5) ? 2'b01 : 2'b10;
            total++;
            if ({rdy2, ro2} !== want) begin
                bad++;
                $display("FAIL min_cfg E%0d got %b want %b", k, {rdy2, ro2}, want);
            end
        end
    endtask

    initial begin
        a_n  = 1'b1;
        sw   = 1'b0;
        a2_n = 1'b1;
        sw2  = 1'b0;
        test_reset();
        test_glitch();
        test_sw_run();
        test_sw_mid_release();
        test_sw_held_assert();
        test_min_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
